up_down_counter_mod: RTL and testbench

UP_DOWN_COUNTER_MOD -- requirements
Module: up_down_counter_mod

---
 rtl/udc_pkg.sv | 15 +
 rtl/udc_next.sv | 64 ++++++
 rtl/up_down_counter_mod.sv | 73 +++++++
 tb/tb_up_down_counter_mod.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/udc_pkg.sv
// Shared constants and types for the up/down counter.
// The saturate option is enabled at build time by defining UDC_SATURATE_EN.
package udc_pkg;

    localparam logic UDC_UP   = 1'b1;
    localparam logic UDC_DOWN = 1'b0;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        WRAP_HI = 2'd1,
        WRAP_LO = 2'd2,
        SAT     = 2'd3
    } udc_evt_e;

endpackage : udc_pkg

// File: rtl/udc_next.sv
// Combinational next-count and boundary-event computation for one enabled step.
// Saturation behaviour exists only when UDC_SATURATE_EN is defined; otherwise sat is ignored.
module udc_next
    import udc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] max_val,
    input  logic             updown,
    input  logic             sat,
    output logic [WIDTH-1:0] next_count,
    output udc_evt_e         evt
);

    logic             sat_on;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;

`ifdef UDC_SATURATE_EN
    assign sat_on = sat;
`else
    assign sat_on = sat & 1'b0;
`endif

    assign count_inc = count + WIDTH'(1);
    assign count_dec = count - WIDTH'(1);

    always_comb begin
        next_count = count;
        evt        = NONE;
        // An out-of-range count (max_val lowered) snaps to the boundary in the direction of travel.
        if (count > max_val) begin
            next_count = (updown == UDC_UP) ? '0 : max_val;
            evt        = (updown == UDC_UP) ? WRAP_HI : WRAP_LO;
        end else if (updown == UDC_UP) begin
            if (count == max_val) begin
                // A zero-width range always wraps so tc keeps pulsing every enabled cycle.
                if (sat_on && (max_val != '0)) begin
                    next_count = count;
                end else begin
                    next_count = '0;
                    evt        = WRAP_HI;
                end
            end else begin
                next_count = count_inc;
                evt        = (sat_on && (count_inc == max_val)) ? SAT : NONE;
            end
        end else begin
            if (count == '0) begin
                if (sat_on && (max_val != '0)) begin
                    next_count = count;
                end else begin
                    next_count = max_val;
                    evt        = WRAP_LO;
                end
            end else begin
                next_count = count_dec;
                evt        = (sat_on && (count == WIDTH'(1))) ? SAT : NONE;
            end
        end
    end

endmodule : udc_next

// File: rtl/up_down_counter_mod.sv
// Up/down counter over 0..max_val with load, terminal-count pulse and sticky boundary flag.
// Build option UDC_SATURATE_EN makes the sat input select saturate instead of wrap.
module up_down_counter_mod
    import udc_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             updown,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_count;
    logic [WIDTH-1:0] rst_count;
    udc_evt_e         step_evt;

    udc_next #(.WIDTH(WIDTH)) u_next (
        .count      (count_q),
        .max_val    (max_val),
        .updown     (updown),
        .sat        (sat),
        .next_count (step_count),
        .evt        (step_evt)
    );

    assign rst_count = (RST_V > max_val) ? max_val : RST_V;

    // Load beats enable; a load also clears the sticky flag.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (load) begin
            count_d = (load_val > max_val) ? max_val : load_val;
            ovf_d   = 1'b0;
        end else if (en) begin
            count_d = step_count;
            tc_d    = (step_evt != NONE);
            ovf_d   = ovf_q | (step_evt != NONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= rst_count;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule : up_down_counter_mod

// File: tb/tb_up_down_counter_mod.sv
// Directed bench for up_down_counter_mod (WIDTH=4, RST_VAL=3) with hand-computed expectations.
// Saturation expectations follow UDC_SATURATE_EN when it is defined for the build.
module tb_up_down_counter_mod;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       updown;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] max_val;
    logic       sat;
    logic [3:0] count;
    logic       tc;
    logic       ovf;

    int vectors     = 0;
    int miscompares = 0;

    up_down_counter_mod #(.WIDTH(4), .RST_VAL(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .updown   (updown),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
        .sat      (sat),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input int c, input bit t, input bit o);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".tc"},    32'(tc),    32'(t));
        chk({tag, ".ovf"},   32'(ovf),   32'(o));
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; updown = 1'b1; load = 1'b1;
        load_val = 4'd5; max_val = 4'd9; sat = 1'b0;
        #1;
        step();
        chk3("reset", 3, 1'b0, 1'b0);

        rst = 1'b1; load = 1'b1; load_val = 4'd0; en = 1'b0;
        step();
        chk3("load0", 0, 1'b0, 1'b0);

        load = 1'b0; en = 1'b1; updown = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk3("up", i, 1'b0, 1'b0);
        end
        step();
        chk3("up_wrap", 0, 1'b1, 1'b1);
        step();
        chk3("up_after_wrap", 1, 1'b0, 1'b1);

        load = 1'b1; load_val = 4'd2; updown = 1'b0;
        step();
        chk3("load2", 2, 1'b0, 1'b0);
        load = 1'b0;
        step(); chk3("dn1", 1, 1'b0, 1'b0);
        step(); chk3("dn0", 0, 1'b0, 1'b0);
        step(); chk3("dn_wrap", 9, 1'b1, 1'b1);
        step(); chk3("dn8", 8, 1'b0, 1'b1);

        load = 1'b1; load_val = 4'd12; en = 1'b0;
        step();
        chk3("load_clamp", 9, 1'b0, 1'b0);
        load = 1'b0;
        step();
        chk3("hold", 9, 1'b0, 1'b0);

        load = 1'b1; load_val = 4'd7;
        step();
        chk("load7", 32'(count), 32'd7);
        load = 1'b0; en = 1'b1; max_val = 4'd5; updown = 1'b1;
        step();
        chk3("over_up", 0, 1'b1, 1'b1);
        max_val = 4'd9; load = 1'b1; load_val = 4'd7;
        step();
        chk3("reload7", 7, 1'b0, 1'b0);
        load = 1'b0; max_val = 4'd5; updown = 1'b0;
        step();
        chk3("over_dn", 5, 1'b1, 1'b1);

        max_val = 4'd0;
        step(); chk3("max0_a", 0, 1'b1, 1'b1);
        step(); chk3("max0_b", 0, 1'b1, 1'b1);
        updown = 1'b1;
        step(); chk3("max0_c", 0, 1'b1, 1'b1);

        max_val = 4'd15; sat = 1'b1; load = 1'b1; load_val = 4'd13;
        step();
        chk3("load13", 13, 1'b0, 1'b0);
        load = 1'b0; updown = 1'b1;
        step(); chk3("s14", 14, 1'b0, 1'b0);
`ifdef UDC_SATURATE_EN
        step(); chk3("s15", 15, 1'b1, 1'b1);
        step(); chk3("s15_hold", 15, 1'b0, 1'b1);
        step(); chk3("s15_hold2", 15, 1'b0, 1'b1);
`else
        step(); chk3("s15", 15, 1'b0, 1'b0);
        step(); chk3("s_wrap", 0, 1'b1, 1'b1);
`endif
        sat = 1'b0;

        load = 1'b1; load_val = 4'd3;
        step();
        load = 1'b0; updown = 1'b1;
        step(); chk3("dir_up", 4, 1'b0, 1'b0);
        updown = 1'b0;
        step(); chk3("dir_dn", 3, 1'b0, 1'b0);
        step(); chk3("dir_dn2", 2, 1'b0, 1'b0);

        load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0;
        step(); chk3("pre_rst_wrap", 15, 1'b1, 1'b1);

        rst = 1'b0; load = 1'b1; load_val = 4'd9; en = 1'b1; updown = 1'b1;
        step();
        chk3("mid_reset", 3, 1'b0, 1'b0);
        rst = 1'b1; load = 1'b0;
        step();
        chk3("resume", 4, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_up_down_counter_mod
